// File: rtl/std_seq_addsub.sv
// Digit-serial add/subtract with go/done handshake: SLICE bits per cycle, LSB first.
// Optional build macro STD_SEQ_ADDSUB_SAT_EN clamps the result to the signed limit on overflow.
module std_seq_addsub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             sub,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic             done
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("std_seq_addsub: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  // Handshake: go is sampled only in IDLE; done is high for exactly the one
  // cycle after the completion edge, and out/carry/ovf hold until the next one.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] result_next;
  logic [WIDTH-1:0] final_out;
  logic [CNT_W-1:0] beat;
  logic             cy;
  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE:0]   slice_sum;
  logic             last;
  logic             ovf_next;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: if (go) state_next = RUN;
      RUN:  if (last) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One narrow adder; B is pre-inverted and carry-in seeded with 1 for subtract.
  always_comb begin
    a_slice   = a_q[beat*SLICE +: SLICE];
    b_slice   = b_q[beat*SLICE +: SLICE];
    slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, cy};
    last      = (beat == CNT_W'(N - 1));
    ovf_next  = (a_slice[SLICE-1] == b_slice[SLICE-1]) &&
                (slice_sum[SLICE-1] != a_slice[SLICE-1]);
  end

  always_comb begin
    result_next = shadow;
    result_next[beat*SLICE +: SLICE] = slice_sum[SLICE-1:0];
  end

`ifdef STD_SEQ_ADDSUB_SAT_EN
  always_comb begin
    final_out = result_next;
    if (ovf_next) begin
      final_out = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign final_out = result_next;
`endif

  // Datapath: operands captured on accept; visible outputs move only on the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      shadow <= '0;
      beat   <= '0;
      cy     <= 1'b0;
      out    <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            a_q  <= left;
            b_q  <= sub ? ~right : right;
            cy   <= sub;
            beat <= '0;
          end
        end
        RUN: begin
          shadow <= result_next;
          cy     <= slice_sum[SLICE];
          beat   <= beat + CNT_W'(1);
          if (last) begin
            out   <= final_out;
            carry <= slice_sum[SLICE];
            ovf   <= ovf_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/std_seq_addsub.md
# std_seq_addsub

Digit-serial, parametrised add/subtract unit with a go/done handshake. It processes `SLICE` bits per cycle, LSB first, and registers the full result, so one narrow adder serves a wide datapath. It is the sequential, mode-selectable generalisation of the team's combinational `std_` arithmetic primitives paired with `std_reg`. It sits in user designs wherever a Calyx-style controller drives arithmetic through go/done, trading latency for fabric area.

## Interface
- `WIDTH`, 32: operand/result width; must be a multiple of `SLICE`.
- `SLICE`, 8: bits processed per cycle; 1 ≤ `SLICE` ≤ `WIDTH`. N = `WIDTH`/`SLICE` beats.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `go` input 1: start request, sampled only in IDLE.
- `sub` input 1: mode, latched with operands; 0 = left+right, 1 = left−right.
- `left` input `WIDTH`: operand A, latched on accepted go.
- `right` input `WIDTH`: operand B, latched on accepted go.
- `out` output `WIDTH`: result; stable between updates.
- `carry` output 1: unsigned carry-out. For sub, 1 means no borrow (left ≥ right unsigned).
- `ovf` output 1: two's-complement signed overflow of the operation.
- `done` output 1: one-cycle pulse when `out`/`carry`/`ovf` are valid.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE:
  - On `go`=1, latch `left`, `right`, `sub`.
  - Set beat counter to 0 and carry-in to `sub`; the operand B path uses `~right` when `sub`=1.
  - Go to RUN.
- RUN, each cycle:
  - Add slice [beat] of A and B (processed B) with the running carry; write the sum slice into a shadow result register; update the running carry.
  - Track the sign bits of the final slice for `ovf`: ovf = (A[msb]==B'[msb]) && (sum[msb]!=A[msb]), where B' is the processed B.
  - After beat N−1, copy shadow → `out` and set `carry`/`ovf` in the same edge; go to DONE.
- DONE: `done`=1 for exactly this cycle; unconditional → IDLE.
- `go` in RUN or DONE is ignored. No queuing.
- `go` held high continuously: a new operation is accepted in the first IDLE cycle after DONE, so the period is N+2 cycles.
- `out`, `carry`, `ovf` change only on the completion edge or on reset. Intermediate slices are never visible on `out`.
- Arithmetic is modulo 2^`WIDTH` unless saturation is compiled in (see Configuration).

## Timing
- Reset values: `out`=0, `carry`=0, `ovf`=0, `done`=0, state IDLE, counter 0.
- Let `go` be sampled at edge k.
  - RUN beats execute at edges k+1 … k+N.
  - `out`/`carry`/`ovf` update at edge k+N.
  - `done`=1 in the cycle after edge k+N, deasserted at edge k+N+1.
  - Latency from go to done is N cycles. Example: WIDTH=32, SLICE=8 gives done 4 cycles after go.
- SLICE=WIDTH (N=1): a single RUN cycle; done 1 cycle after go.
- Reset mid-operation, in any state: at the next edge all outputs return to reset values and the in-flight result is discarded. No `done` pulse is emitted for the aborted operation.
- Reset and `go` asserted together: reset wins; `go` is not accepted.
- Operand inputs may change freely after the accepting edge without affecting the result.

## Configuration
- `STD_SEQ_ADDSUB_SAT_EN` defined:
  - When `ovf`=1, `out` is clamped to the signed limit: 0x7FFF_FFFF if A[msb]=0, 0x8000_0000 if A[msb]=1 (for WIDTH=32).
  - `ovf` still reports the overflow event. `carry` is unchanged.
- Not defined: wrap-around result, no clamping logic generated. `ovf`/`carry` behave identically in both builds.

## Test plan
- Add, WIDTH=32, SLICE=8: left=0x0000_00FF, right=0x0000_0001, sub=0, go pulse → `done` 4 cycles later; `out`=0x0000_0100, `carry`=0, `ovf`=0. Carry propagates across the slice boundary.
- Sub with borrow: left=5, right=7, sub=1 → `out`=0xFFFF_FFFE, `carry`=0, `ovf`=0.
- Signed overflow: left=0x7FFF_FFFF, right=1, sub=0 → `ovf`=1. `out`=0x8000_0000 without the macro; `out`=0x7FFF_FFFF with `STD_SEQ_ADDSUB_SAT_EN`.
- Busy and back-to-back:
  - `go` re-pulsed during RUN with new operands → ignored; the first result is unaffected.
  - `go` held high → `done` every 6 cycles (N+2) with correct results.
- Reset mid-op: assert `reset` at beat 2 → next cycle `out`=0, `done`=0. No `done` pulse follows. The next `go` completes normally.
- Degenerate slice: WIDTH=16, SLICE=16, left=0xFFFF, right=0x0001, sub=0 → `done` 1 cycle after go; `out`=0x0000, `carry`=1, `ovf`=0.
